// File: rtl/s2_pkg.sv
// Shared definitions for the S2 demux slot block: slot states, slot count, ACT-style select.
package s2_pkg;

   localparam int unsigned NSLOT = 4;
   localparam int unsigned SEL_W = 2;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Slot index {S1,S0} with S1 = A1 & B1, S0 = A0 | B0.
   function automatic logic [SEL_W-1:0] act_sel(input logic a1, input logic b1,
                                                 input logic a0, input logic b0);
      return {a1 & b1, a0 | b0};
   endfunction

endpackage

// File: rtl/s2_slot.sv
// One output holding slot: data register plus EMPTY/FULL state, drained by valid/ack.
module s2_slot
   import s2_pkg::*;
#(
   parameter int unsigned size = 5
) (
   input  logic            clk,
   input  logic            CLRn,
   input  logic            load,
   input  logic [size-1:0] D,
   input  logic            ack,
   output logic [size-1:0] Q,
   output logic            valid
);

   slot_state_e state, state_nxt;

   // Data only moves on load; an ack alone keeps the old value and just drops valid.
   always_ff @(posedge clk) begin
      if (!CLRn) begin
         state <= SLOT_EMPTY;
         Q     <= '0;
      end else begin
         state <= state_nxt;
         if (load) Q <= D;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SLOT_EMPTY: if (load)         state_nxt = SLOT_FULL;
         SLOT_FULL:  if (ack && !load) state_nxt = SLOT_EMPTY;
         default:                      state_nxt = SLOT_EMPTY;
      endcase
   end

   assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/s2_demux_slot.sv
// Registered 1-to-4 distributor: steers one ready/valid input word into one of four ack-drained slots.
module s2_demux_slot
   import s2_pkg::*;
#(
   parameter int unsigned size  = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             CLRn,
   input  logic [size-1:0]  D,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             A1,
   input  logic             B1,
   input  logic             A0,
   input  logic             B0,
   output logic [size-1:0]  Q0,
   output logic [size-1:0]  Q1,
   output logic [size-1:0]  Q2,
   output logic [size-1:0]  Q3,
   output logic [NSLOT-1:0] Q_valid,
   input  logic [NSLOT-1:0] Q_ack,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [SEL_W-1:0] sel_c;
   logic [NSLOT-1:0] load_c;
   logic [NSLOT-1:0] valid_a;
   logic [size-1:0]  q_a [NSLOT];

   assign sel_c = act_sel(A1, B1, A0, B0);

   // A full slot being acked this cycle can take a new word in the same cycle.
   assign in_ready = !valid_a[sel_c] || Q_ack[sel_c];

   always_comb begin
      load_c = '0;
      load_c[sel_c] = in_valid && in_ready;
   end

   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      s2_slot #(.size(size)) u_slot (
         .clk   (clk),
         .CLRn  (CLRn),
         .load  (load_c[k]),
         .D     (D),
         .ack   (Q_ack[k]),
         .Q     (q_a[k]),
         .valid (valid_a[k])
      );
   end

   assign Q0      = q_a[0];
   assign Q1      = q_a[1];
   assign Q2      = q_a[2];
   assign Q3      = q_a[3];
   assign Q_valid = valid_a;

   // Saturating count of cycles the producer was held off.
   always_ff @(posedge clk) begin
      if (!CLRn) begin
         stall_cnt <= '0;
      end else if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
